// File: rtl/cdb_arbiter_if.sv
// Common-data-bus arbiter: shared packet type and bus interface.
//   cdb_pkg::writeback_packet_t : {result, dest_tag, is_valid}
//   cdb_arbiter_if              : FU result ports, flush, grants, CDB broadcast, debug pointer
//     master : FU/issue side (drives fu_result, flush)
//     slave  : arbiter side (drives fu_cdb_gnt, cdb_out, rr_ptr_o)
package cdb_pkg;
  typedef struct packed {
    logic [31:0] result;
    logic [5:0]  dest_tag;
    logic        is_valid;
  } writeback_packet_t;
endpackage

interface cdb_arbiter_if #(
  parameter int NUM_FU   = 4,
  parameter int PTR_BITS = $clog2(NUM_FU)
);
  import cdb_pkg::*;

  logic                           flush;
  writeback_packet_t [NUM_FU-1:0] fu_result;
  logic [NUM_FU-1:0]              fu_cdb_gnt;
  writeback_packet_t              cdb_out;
  logic [PTR_BITS-1:0]            rr_ptr_o;

  modport master (output flush, fu_result, input fu_cdb_gnt, cdb_out, rr_ptr_o);
  modport slave  (input flush, fu_result, output fu_cdb_gnt, cdb_out, rr_ptr_o);
endinterface

// File: rtl/cdb_arbiter.sv
// Round-robin common-data-bus arbiter.
//   clk, rst_n : clock, async active-low reset
//   bus.slave  : fu_result[NUM_FU] requests (is_valid), flush,
//                fu_cdb_gnt (comb one-hot/zero), cdb_out (registered, 1-cycle pulse),
//                rr_ptr_o (search start for the next arbitration)
// FUs hold their packet until granted, so nothing is buffered here.

// Per-FU lane: request qualification and grant-gated packet for the AND-OR mux.
module cdb_lane
  import cdb_pkg::*;
(
  input  logic              flush,
  input  logic              gnt,
  input  writeback_packet_t pkt,
  output logic              req,
  output writeback_packet_t pkt_sel
);
  assign req     = pkt.is_valid & ~flush;
  assign pkt_sel = gnt ? pkt : '0;
endmodule

module cdb_arbiter
  import cdb_pkg::*;
#(
  parameter int NUM_FU   = 4,
  parameter int PTR_BITS = $clog2(NUM_FU)
) (
  input  logic          clk,
  input  logic          rst_n,
  cdb_arbiter_if.slave  bus
);

  if (NUM_FU < 2 || NUM_FU > 8) begin : g_bad_num_fu
    $error("cdb_arbiter: NUM_FU must be 2..8");
  end

  logic [NUM_FU-1:0]              req;
  logic [NUM_FU-1:0]              gnt;
  writeback_packet_t [NUM_FU-1:0] pkt_sel;
  writeback_packet_t              bcast;
  writeback_packet_t              cdb_q;
  logic [PTR_BITS-1:0]            rr_ptr;
  logic [PTR_BITS-1:0]            win;
  logic [PTR_BITS-1:0]            nxt_ptr;
  logic                           found;

  for (genvar i = 0; i < NUM_FU; i++) begin : g_lane
    cdb_lane u_lane (
      .flush   (bus.flush),
      .gnt     (gnt[i]),
      .pkt     (bus.fu_result[i]),
      .req     (req[i]),
      .pkt_sel (pkt_sel[i])
    );
  end

  // Rotating priority search starting at rr_ptr; flush already masks req.
  always_comb begin
    gnt   = '0;
    win   = '0;
    found = 1'b0;
    for (int k = 0; k < NUM_FU; k++) begin
      if (!found && req[(int'(rr_ptr) + k) % NUM_FU]) begin
        found = 1'b1;
        win   = PTR_BITS'((int'(rr_ptr) + k) % NUM_FU);
        gnt[(int'(rr_ptr) + k) % NUM_FU] = 1'b1;
      end
    end
    // Grant must be dead while reset is held even if FUs still request.
    if (!rst_n) gnt = '0;
  end

  // AND-OR mux of the one-hot gated lanes; zero when nothing is granted.
  always_comb begin
    bcast = '0;
    for (int i = 0; i < NUM_FU; i++) begin
      bcast = writeback_packet_t'(bcast | pkt_sel[i]);
    end
    bcast.is_valid = found;
  end

  assign nxt_ptr = (win == PTR_BITS'(NUM_FU - 1)) ? '0 : win + 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cdb_q  <= '0;
      rr_ptr <= '0;
    end else begin
      cdb_q <= bcast;
      if (found) rr_ptr <= nxt_ptr;
    end
  end

  assign bus.fu_cdb_gnt = gnt;
  assign bus.cdb_out    = cdb_q;
  assign bus.rr_ptr_o   = rr_ptr;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Testbench for cdb_arbiter (NUM_FU=4): scoreboarded broadcast checks plus
// inline grant / pointer checks per scenario.
module tb_cdb_arbiter;
  import cdb_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  cdb_arbiter_if #(.NUM_FU(4)) bus ();

  cdb_arbiter #(.NUM_FU(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int tests = 0;
  int errors = 0;
  int m_ptr = 0;
  int seq = 0;
  logic [3:0] req = '0;
  logic flsh = 1'b0;
  writeback_packet_t pend [4];
  writeback_packet_t sb [$];

  function automatic writeback_packet_t mk(int port, int n);
    writeback_packet_t p;
    p.result   = 32'hC0DE_0000 + 32'(port << 8) + 32'(n);
    p.dest_tag = 6'((port * 5 + n) % 64);
    p.is_valid = 1'b1;
    return p;
  endfunction

  function automatic int model_win(logic [3:0] r, logic fl, int p);
    if (fl) return -1;
    for (int k = 0; k < 4; k++) if (r[(p + k) % 4]) return (p + k) % 4;
    return -1;
  endfunction

  task automatic apply();
    for (int i = 0; i < 4; i++) begin
      bus.fu_result[i] = pend[i];
      bus.fu_result[i].is_valid = req[i];
    end
    bus.flush = flsh;
  endtask

  task automatic test_reset();
    req = 4'b1111;
    apply();
    #2;
    tests++; if (bus.fu_cdb_gnt !== 4'b0) begin errors++; $display("FAIL reset_gnt: got %b want 0000", bus.fu_cdb_gnt); end
    tests++; if (bus.cdb_out !== '0) begin errors++; $display("FAIL reset_cdb: got %h want 0", bus.cdb_out); end
    tests++; if (bus.rr_ptr_o !== 2'd0) begin errors++; $display("FAIL reset_ptr: got %0d want 0", bus.rr_ptr_o); end
    @(posedge clk); #1;
    tests++; if (bus.cdb_out !== '0) begin errors++; $display("FAIL reset_cdb_clk: got %h want 0", bus.cdb_out); end
    req = '0;
    apply();
    rst_n = 1'b1;
    m_ptr = 0;
  endtask

  task automatic test_single();
    writeback_packet_t ex;
    int w;
    logic [3:0] eg;
    pend[2] = '{result: 32'h1234, dest_tag: 6'd5, is_valid: 1'b1};
    req = 4'b0100;
    for (int c = 0; c < 2; c++) begin
      apply();
      @(negedge clk);
      w = model_win(req, flsh, m_ptr);
      eg = (w < 0) ? 4'b0 : 4'(1 << w);
      tests++; if (bus.fu_cdb_gnt !== eg) begin errors++; $display("FAIL single_gnt c%0d: got %b want %b", c, bus.fu_cdb_gnt, eg); end
      ex = '0; if (w >= 0) begin ex = pend[w]; ex.is_valid = 1'b1; end
      sb.push_back(ex);
      @(posedge clk); #1;
      if (w >= 0) begin m_ptr = (w + 1) % 4; req[w] = 1'b0; end
      ex = sb.pop_front();
      tests++; if (bus.cdb_out !== ex) begin errors++; $display("FAIL single_cdb c%0d: got %h want %h", c, bus.cdb_out, ex); end
      tests++; if (bus.rr_ptr_o !== 2'(m_ptr)) begin errors++; $display("FAIL single_ptr c%0d: got %0d want %0d", c, bus.rr_ptr_o, m_ptr); end
    end
  endtask

  // FU1 broadcast, then a flush cycle with FU0 (tag 0) pending, then FU0 wins.
  task automatic test_flush();
    writeback_packet_t ex, last;
    int w;
    logic [3:0] eg;
    logic [3:0] add [3] = '{4'b0010, 4'b0001, 4'b0000};
    logic       fl  [3] = '{1'b0, 1'b1, 1'b0};
    last = '0;
    pend[1] = mk(1, seq++);
    pend[0] = mk(0, 0);
    for (int c = 0; c < 3; c++) begin
      req = req | add[c];
      flsh = fl[c];
      apply();
      @(negedge clk);
      w = model_win(req, flsh, m_ptr);
      eg = (w < 0) ? 4'b0 : 4'(1 << w);
      tests++; if (bus.fu_cdb_gnt !== eg) begin errors++; $display("FAIL flush_gnt c%0d: got %b want %b", c, bus.fu_cdb_gnt, eg); end
      if (flsh) begin
        tests++; if (bus.cdb_out !== last) begin errors++; $display("FAIL flush_hold_cdb: got %h want %h", bus.cdb_out, last); end
      end
      ex = '0; if (w >= 0) begin ex = pend[w]; ex.is_valid = 1'b1; end
      sb.push_back(ex);
      @(posedge clk); #1;
      if (w >= 0) begin m_ptr = (w + 1) % 4; req[w] = 1'b0; end
      ex = sb.pop_front();
      last = ex;
      tests++; if (bus.cdb_out !== ex) begin errors++; $display("FAIL flush_cdb c%0d: got %h want %h", c, bus.cdb_out, ex); end
      tests++; if (bus.rr_ptr_o !== 2'(m_ptr)) begin errors++; $display("FAIL flush_ptr c%0d: got %0d want %0d", c, bus.rr_ptr_o, m_ptr); end
    end
    flsh = 1'b0;
  endtask

  // FU2 alone (ptr -> 3), FU1+FU3 (FU3 wins, ptr -> 0), FU1 still pending (ptr -> 2).
  task automatic test_rr_skip();
    writeback_packet_t ex;
    int w;
    logic [3:0] eg;
    logic [3:0] add [3] = '{4'b0100, 4'b1010, 4'b0000};
    for (int i = 1; i < 4; i++) pend[i] = mk(i, seq++);
    for (int c = 0; c < 3; c++) begin
      req = req | add[c];
      apply();
      @(negedge clk);
      w = model_win(req, flsh, m_ptr);
      eg = (w < 0) ? 4'b0 : 4'(1 << w);
      tests++; if (bus.fu_cdb_gnt !== eg) begin errors++; $display("FAIL rr_gnt c%0d: got %b want %b", c, bus.fu_cdb_gnt, eg); end
      ex = '0; if (w >= 0) begin ex = pend[w]; ex.is_valid = 1'b1; end
      sb.push_back(ex);
      @(posedge clk); #1;
      if (w >= 0) begin m_ptr = (w + 1) % 4; req[w] = 1'b0; end
      ex = sb.pop_front();
      tests++; if (bus.cdb_out !== ex) begin errors++; $display("FAIL rr_cdb c%0d: got %h want %h", c, bus.cdb_out, ex); end
      tests++; if (bus.rr_ptr_o !== 2'(m_ptr)) begin errors++; $display("FAIL rr_ptr c%0d: got %0d want %0d", c, bus.rr_ptr_o, m_ptr); end
    end
  endtask

  task automatic test_idle();
    req = '0;
    apply();
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      tests++; if (bus.fu_cdb_gnt !== 4'b0) begin errors++; $display("FAIL idle_gnt c%0d: got %b want 0000", c, bus.fu_cdb_gnt); end
      @(posedge clk); #1;
      tests++; if (bus.cdb_out.is_valid !== 1'b0) begin errors++; $display("FAIL idle_valid c%0d: got %b want 0", c, bus.cdb_out.is_valid); end
      tests++; if (bus.rr_ptr_o !== 2'(m_ptr)) begin errors++; $display("FAIL idle_ptr c%0d: got %0d want %0d", c, bus.rr_ptr_o, m_ptr); end
    end
  endtask

  task automatic test_mid_reset();
    writeback_packet_t ex;
    int w;
    pend[3] = mk(3, seq++);
    req = 4'b1000;
    apply();
    @(negedge clk);
    w = model_win(req, flsh, m_ptr);
    ex = pend[3];
    sb.push_back(ex);
    @(posedge clk); #1;
    if (w >= 0) begin m_ptr = (w + 1) % 4; req[w] = 1'b0; end
    ex = sb.pop_front();
    tests++; if (bus.cdb_out !== ex) begin errors++; $display("FAIL mrst_pre_cdb: got %h want %h", bus.cdb_out, ex); end
    pend[0] = mk(0, seq++);
    req = 4'b0001;
    apply();
    #3 rst_n = 1'b0;
    #1;
    tests++; if (bus.cdb_out !== '0) begin errors++; $display("FAIL mrst_cdb: got %h want 0", bus.cdb_out); end
    tests++; if (bus.fu_cdb_gnt !== 4'b0) begin errors++; $display("FAIL mrst_gnt: got %b want 0000", bus.fu_cdb_gnt); end
    tests++; if (bus.rr_ptr_o !== 2'd0) begin errors++; $display("FAIL mrst_ptr: got %0d want 0", bus.rr_ptr_o); end
    req = '0;
    apply();
    sb.delete();
    m_ptr = 0;
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  // All four persistent (each re-arms with fresh data), then FU2 alone persistent.
  task automatic test_back_to_back();
    writeback_packet_t ex;
    int w;
    logic [3:0] eg;
    for (int i = 0; i < 4; i++) pend[i] = mk(i, seq++);
    for (int c = 0; c < 11; c++) begin
      req = (c < 8) ? 4'b1111 : 4'b0100;
      apply();
      @(negedge clk);
      w = model_win(req, flsh, m_ptr);
      eg = (w < 0) ? 4'b0 : 4'(1 << w);
      tests++; if (bus.fu_cdb_gnt !== eg) begin errors++; $display("FAIL b2b_gnt c%0d: got %b want %b", c, bus.fu_cdb_gnt, eg); end
      ex = '0; if (w >= 0) begin ex = pend[w]; ex.is_valid = 1'b1; end
      sb.push_back(ex);
      @(posedge clk); #1;
      if (w >= 0) begin m_ptr = (w + 1) % 4; pend[w] = mk(w, seq++); end
      ex = sb.pop_front();
      tests++; if (bus.cdb_out !== ex) begin errors++; $display("FAIL b2b_cdb c%0d: got %h want %h", c, bus.cdb_out, ex); end
      tests++; if (bus.rr_ptr_o !== 2'(m_ptr)) begin errors++; $display("FAIL b2b_ptr c%0d: got %0d want %0d", c, bus.rr_ptr_o, m_ptr); end
    end
    req = '0;
    apply();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 4; i++) pend[i] = '0;
    apply();
    test_reset();
    test_single();
    test_flush();
    test_rr_skip();
    test_idle();
    test_mid_reset();
    test_back_to_back();
    tests++; if (sb.size() !== 0) begin errors++; $display("FAIL sb_drain: got %0d want 0", sb.size()); end
    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule

// File: doc/cdb_arbiter.md
CDB_ARBITER -- requirements
Module: cdb_arbiter

Interface
- REQ-001: Parameter NUM_FU, default 4, is the number of functional-unit result ports; legal range is 2 to 8.
- REQ-002: Parameter PTR_BITS, default $clog2(NUM_FU), is the width of the round-robin pointer.
- REQ-003: clk  input  1  single clock; all state SHALL update on its rising edge.
- REQ-004: rst_n  input  1  asynchronous, active-low reset.
- REQ-005: flush  input  1  pipeline flush, synchronous, active-high.
- REQ-006: fu_result  input  writeback_packet_t[NUM_FU]  FU result ports; the request for port i is fu_result[i].is_valid.
- REQ-007: fu_cdb_gnt  output  NUM_FU  per-FU grant, combinational and one-hot or zero.
- REQ-008: cdb_out  output  writeback_packet_t  registered common-data-bus broadcast with fields result, dest_tag and is_valid.
- REQ-009: rr_ptr_o  output  PTR_BITS  current round-robin pointer, for debug and verification.

Function
- REQ-010: An FU SHALL hold its packet stable with is_valid=1 until it sees fu_cdb_gnt[i]=1 on a rising edge; the arbiter relies on this and SHALL NOT buffer un-granted requests.
- REQ-011: Each cycle, at most one fu_cdb_gnt bit SHALL be 1.
  - The winner is the first requesting port found searching from index rr_ptr upward, wrapping modulo NUM_FU.
- REQ-012: With no requests, or with flush=1, fu_cdb_gnt SHALL be all-zero.
- REQ-013: Grant SHALL depend only on the current-cycle is_valid bits, rr_ptr and flush, with no other combinational inputs.
- REQ-014: On a rising edge with a grant to port w, cdb_out SHALL load fu_result[w] with is_valid forced to 1.
  - Latency is exactly 1 cycle from grant to broadcast.
- REQ-015: On a rising edge with no grant, cdb_out SHALL be loaded with all-zero.
  - A broadcast is therefore visible for exactly one cycle.
- REQ-016: On a rising edge with a grant to port w, rr_ptr SHALL become (w+1) mod NUM_FU, wrapping from NUM_FU-1 to 0.
  - With no grant, rr_ptr SHALL hold.
- REQ-017: Throughput SHALL be one broadcast per cycle; back-to-back grants to different ports SHALL produce back-to-back cdb_out packets.
- REQ-018: A single persistent requester SHALL be granted every cycle it requests.
  - Example: it releases after 1 grant and re-requests the next cycle.
- REQ-019: Fairness: with all NUM_FU ports requesting continuously, each port SHALL be granted exactly once in any NUM_FU consecutive cycles.
- REQ-020: Flush SHALL have priority over all requests.
  - The cycle flush=1 SHALL issue no grant.
  - cdb_out SHALL be all-zero after that edge.
  - rr_ptr SHALL hold.
- REQ-021: A packet already registered in cdb_out before the flush edge SHALL remain visible during the flush cycle; it is not retracted combinationally.
- REQ-022: A request whose dest_tag is 0 SHALL be arbitrated and broadcast like any other; the arbiter SHALL NOT interpret tag values.

Reset
- REQ-023: While rst_n=0, independent of clk: cdb_out SHALL be all-zero, rr_ptr SHALL be 0, and fu_cdb_gnt SHALL be all-zero.
- REQ-024: On rst_n deassertion, the first grant SHALL follow REQ-011 with rr_ptr=0.
- REQ-025: Reset asserted mid-broadcast SHALL clear cdb_out immediately; the lost packet is not replayed.

Verification
- REQ-026: Reset, then FU2 requests (result=0x1234, tag=5) -> gnt=4'b0100 that cycle; next cycle cdb_out={0x1234,5,valid}; rr_ptr=3.
- REQ-027: All 4 FUs requesting continuously from reset -> grants to ports 0,1,2,3,0,... on consecutive cycles; cdb_out valid every cycle; rr_ptr wraps from 3 to 0.
- REQ-028: rr_ptr=3, requests on FU1 and FU3 -> FU3 granted, rr_ptr=0; next cycle FU1 alone requesting -> FU1 granted, rr_ptr=2.
- REQ-029: FU0 requesting with flush=1 -> gnt=0; cdb_out=0 after the edge; rr_ptr unchanged; flush=0 next cycle -> FU0 granted.
- REQ-030: rst_n pulled low between clock edges while cdb_out is valid -> cdb_out=0 and gnt=0 immediately; rr_ptr=0.
- REQ-031: No requests for 10 cycles -> cdb_out.is_valid=0 throughout and rr_ptr constant.
